// File: rtl/cpu_ext_loader_pkg.sv
// Shared types for the external-memory loader.
// State codes, default widths and the phase-skip helper.
package cpu_ext_loader_pkg;

    localparam int DEF_LEN_W     = 16;
    localparam int DEF_ADDR_STEP = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_I = 3'd1;
    localparam logic [2:0] ST_LOAD_D = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_I = ST_LOAD_I,
        S_LOAD_D = ST_LOAD_D,
        S_RUN    = ST_RUN,
        S_DUMP   = ST_DUMP,
        S_DONE   = ST_DONE
    } state_e;

    // First phase at or after 'from' that has non-zero work.
    function automatic state_e first_phase(
        input state_e from,
        input logic   i_nz,
        input logic   d_nz,
        input logic   r_nz,
        input logic   u_nz
    );
        state_e s;
        s = from;
        if (s == S_LOAD_I && !i_nz) s = S_LOAD_D;
        if (s == S_LOAD_D && !d_nz) s = S_RUN;
        if (s == S_RUN && !r_nz) s = S_DUMP;
        if (s == S_DUMP && !u_nz) s = S_DONE;
        return s;
    endfunction

endpackage

// File: rtl/cpu_ext_loader_out_word_buffer.sv
// Single-entry valid/ready holding register for the dump stream.
// A load always finds the entry empty, so load simply overwrites.
module out_word_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/cpu_ext_loader.sv
// Host-side master for the CPU ext memory ports: load IMEM/DMEM,
// run the CPU for a fixed budget, then stream a DMEM window back.
module cpu_ext_loader
    import cpu_ext_loader_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  imem_len,
    input  logic [LEN_W-1:0]  dmem_len,
    input  logic [31:0]       run_cycles,
    input  logic [31:0]       dump_base,
    input  logic [LEN_W-1:0]  dump_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, ocnt_q, ocnt_d;
    logic [31:0]       run_q, run_d;
    logic              fin_q, fin_d;
    logic [LEN_W-1:0]  ilen_q, ilen_d, dlen_q, dlen_d, ulen_q, ulen_d;
    logic [31:0]       rcyc_q, rcyc_d, base_q, base_d;
    logic              wen_q, wen_d, wen2_q, wen2_d;
    logic              ren2_q, ren2_d, rd_q, rd_d;
    logic [31:0]       addr_q, addr_d, addr2_q, addr2_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata2_q, wdata2_d;
    logic              ob_valid, accept;
    logic [31:0]       step_addr;
    logic              unused_rdata;

    assign unused_rdata = ^rdata_ext;
    assign step_addr    = 32'(cnt_q) * 32'(ADDR_STEP);
    assign in_ready     = (state_q == S_LOAD_I || state_q == S_LOAD_D) && !fin_q;
    assign accept       = in_ready && in_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ocnt_d   = ocnt_q;
        run_d    = run_q;
        fin_d    = fin_q;
        ilen_d   = ilen_q;
        dlen_d   = dlen_q;
        ulen_d   = ulen_q;
        rcyc_d   = rcyc_q;
        base_d   = base_q;
        wen_d    = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        wen2_d   = 1'b0;
        addr2_d  = '0;
        wdata2_d = '0;
        ren2_d   = 1'b0;
        rd_d     = ren2_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ilen_d  = imem_len;
                    dlen_d  = dmem_len;
                    rcyc_d  = run_cycles;
                    base_d  = dump_base;
                    ulen_d  = dump_len;
                    state_d = first_phase(S_LOAD_I, imem_len != '0,
                        dmem_len != '0, run_cycles != '0, dump_len != '0);
                end
            end
            S_LOAD_I: begin
                // fin cycle: last write is on the port, stream paused
                if (fin_q) begin
                    fin_d   = 1'b0;
                    state_d = first_phase(S_LOAD_D, 1'b1,
                        dlen_q != '0, rcyc_q != '0, ulen_q != '0);
                end else if (accept) begin
                    wen_d   = 1'b1;
                    addr_d  = step_addr;
                    wdata_d = in_data;
                    cnt_d   = cnt_q + LEN_W'(1);
                    if (cnt_q == ilen_q - LEN_W'(1)) fin_d = 1'b1;
                end
            end
            S_LOAD_D: begin
                if (fin_q) begin
                    fin_d   = 1'b0;
                    state_d = first_phase(S_RUN, 1'b1, 1'b1,
                        rcyc_q != '0, ulen_q != '0);
                end else if (accept) begin
                    wen2_d   = 1'b1;
                    addr2_d  = step_addr;
                    wdata2_d = in_data;
                    cnt_d    = cnt_q + LEN_W'(1);
                    if (cnt_q == dlen_q - LEN_W'(1)) fin_d = 1'b1;
                end
            end
            S_RUN: begin
                run_d = run_q + 32'd1;
                if (run_q == rcyc_q - 32'd1) begin
                    state_d = first_phase(S_DUMP, 1'b1, 1'b1, 1'b1,
                        ulen_q != '0);
                end
            end
            S_DUMP: begin
                // one read in flight at a time, buffer must be empty
                if (!ren2_q && !rd_q && !ob_valid && cnt_q != ulen_q) begin
                    ren2_d  = 1'b1;
                    addr2_d = base_q + step_addr;
                    cnt_d   = cnt_q + LEN_W'(1);
                end
                if (ob_valid && out_ready) begin
                    ocnt_d = ocnt_q + LEN_W'(1);
                    if (ocnt_q == ulen_q - LEN_W'(1)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d  = '0;
            ocnt_d = '0;
            run_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ocnt_q   <= '0;
            run_q    <= '0;
            fin_q    <= 1'b0;
            ilen_q   <= '0;
            dlen_q   <= '0;
            ulen_q   <= '0;
            rcyc_q   <= '0;
            base_q   <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen2_q   <= 1'b0;
            addr2_q  <= '0;
            wdata2_q <= '0;
            ren2_q   <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ocnt_q   <= ocnt_d;
            run_q    <= run_d;
            fin_q    <= fin_d;
            ilen_q   <= ilen_d;
            dlen_q   <= dlen_d;
            ulen_q   <= ulen_d;
            rcyc_q   <= rcyc_d;
            base_q   <= base_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen2_q   <= wen2_d;
            addr2_q  <= addr2_d;
            wdata2_q <= wdata2_d;
            ren2_q   <= ren2_d;
            rd_q     <= rd_d;
        end
    end

    out_word_buffer #(.DATA_W(DATA_W)) u_obuf (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (rd_q),
        .load_data (rdata_ext_2),
        .out_ready (out_ready),
        .out_valid (ob_valid),
        .out_data  (out_data)
    );

    assign out_valid   = ob_valid;
    assign busy        = state_q != S_IDLE && state_q != S_DONE;
    assign done        = state_q == S_DONE;
    assign cpu_enable  = state_q == S_RUN;
    assign addr_ext    = addr_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_q;
    assign addr_ext_2  = addr2_q;
    assign wen_ext_2   = wen2_q;
    assign ren_ext_2   = ren2_q;
    assign wdata_ext_2 = wdata2_q;

endmodule

// File: tb/tb_cpu_ext_loader.sv
// Directed bench for cpu_ext_loader with a behavioural DMEM
// and negedge monitors logging every ext-port transaction.
module tb_cpu_ext_loader;

    logic        clk = 1'b0;
    logic        arst_n, start;
    logic [15:0] imem_len, dmem_len, dump_len;
    logic [31:0] run_cycles, dump_base;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic        busy, done, cpu_enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;

    always #5 clk = ~clk;

    cpu_ext_loader dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len),
        .run_cycles(run_cycles), .dump_base(dump_base),
        .dump_len(dump_len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext),
        .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2)
    );

    assign rdata_ext = 32'hDEAD_BEEF;

    // DMEM model: preset word i = D000_0000+i, read data one cycle later
    logic [31:0] dmem [256];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'hD000_0000 + i;
            init_done <= 1'b1;
        end else begin
            if (wen_ext_2) dmem[addr_ext_2[9:2]] <= wdata_ext_2;
            if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[9:2]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$], rd_a[$], oq[$];
    int          iw_c[$], dw_c[$], acc_c[$];
    int          en_cnt = 0, en_runs = 0, overlap = 0, bd = 0;
    int          ren_i = 0, unstable = 0, stall_cyc = 0;
    logic        prev_en = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (wen_ext) begin
            iw_a.push_back(addr_ext); iw_d.push_back(wdata_ext);
            iw_c.push_back(cyc);
        end
        if (wen_ext_2) begin
            dw_a.push_back(addr_ext_2); dw_d.push_back(wdata_ext_2);
            dw_c.push_back(cyc);
        end
        if (ren_ext_2) rd_a.push_back(addr_ext_2);
        if (in_valid && in_ready) acc_c.push_back(cyc);
        if (out_valid && out_ready) oq.push_back(out_data);
        if (cpu_enable) en_cnt++;
        if (cpu_enable && !prev_en) en_runs++;
        prev_en = cpu_enable;
        if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2))
            overlap++;
        if (busy && done) bd++;
        if (ren_ext) ren_i++;
        if (prev_stall && out_valid && out_data !== prev_data) unstable++;
        if (out_valid && !out_ready) stall_cyc++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    int n_cmp = 0, n_bad = 0;
    int b_iw, b_dw, b_rd, b_acc, b_oq, b_en, b_runs, b_stall;

    task automatic snap();
        b_iw = iw_a.size(); b_dw = dw_a.size(); b_rd = rd_a.size();
        b_acc = acc_c.size(); b_oq = oq.size(); b_en = en_cnt;
        b_runs = en_runs; b_stall = stall_cyc;
    endtask

    task automatic run_job(
        input logic [15:0] il, input logic [15:0] dl,
        input logic [31:0] rc, input logic [31:0] base,
        input logic [15:0] ul, input logic [31:0] words[8],
        input bit toggle, input bit stall
    );
        @(posedge clk); #1;
        start = 1; imem_len = il; dmem_len = dl;
        run_cycles = rc; dump_base = base; dump_len = ul;
        @(posedge clk); #1;
        start = 0;
        fork
            begin
                int n;
                bit ok;
                for (int i = 0; i < int'(il) + int'(dl); i++) begin
                    in_valid = 1; in_data = words[i];
                    ok = 0; n = 0;
                    while (!ok && n < 200) begin
                        @(negedge clk); ok = in_ready; n++;
                        @(posedge clk); #1;
                    end
                    in_valid = 0;
                    if (toggle) begin @(posedge clk); #1; end
                end
            end
            begin
                int j, n, sc;
                j = 0; n = 0; sc = 0;
                out_ready = 1;
                while (j < int'(ul) && n < 2000) begin
                    @(negedge clk); n++;
                    if (out_valid && out_ready) begin
                        j++;
                        if (stall && j == 1) begin
                            @(posedge clk); #1; out_ready = 0; sc = 0;
                        end
                    end else if (out_valid && !out_ready) begin
                        sc++;
                        if (sc == 4) begin @(posedge clk); #1; out_ready = 1; end
                    end
                end
            end
        join
        for (int n = 0; n < 100 && !done; n++) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL job_done: got %b expected 1", done);
        end
    endtask

    task automatic test_reset();
        logic [199:0] outs;
        arst_n = 0; start = 0; in_valid = 0; in_data = 0; out_ready = 0;
        imem_len = 0; dmem_len = 0; dump_len = 0;
        run_cycles = 0; dump_base = 0;
        repeat (3) @(negedge clk);
        outs = {in_ready, out_valid, out_data, busy, done, cpu_enable,
                addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2,
                wen_ext_2, ren_ext_2, wdata_ext_2};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++; $display("FAIL reset_outs: got %h expected 0", outs);
        end
        @(posedge clk); #1; arst_n = 1; out_ready = 1;
        @(posedge clk); #1;
        start = 1; imem_len = 3; dmem_len = 1; run_cycles = 1;
        dump_len = 1;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_data = 32'hE1;
        @(posedge clk); #1; in_data = 32'hE2;
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk);
        n_cmp++;
        if ({busy, wen_ext} !== 2'b11) begin
            n_bad++; $display("FAIL midload_active: got %b expected 11",
                {busy, wen_ext});
        end
        #1 arst_n = 0;
        #1;
        outs = {in_ready, out_valid, out_data, busy, done, cpu_enable,
                addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2,
                wen_ext_2, ren_ext_2, wdata_ext_2};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++; $display("FAIL midjob_reset_outs: got %h expected 0", outs);
        end
        @(posedge clk); #1; arst_n = 1;
    endtask

    task automatic test_zero_len();
        snap();
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL zero_pre_done: got %b expected 0", done);
        end
        @(posedge clk); #1;
        start = 1; imem_len = 0; dmem_len = 0; run_cycles = 0;
        dump_len = 0; dump_base = 32'h100;
        @(posedge clk); #1; start = 0;
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_bad++; $display("FAIL zero_done: got %b expected 10", {done, busy});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (iw_a.size() - b_iw + dw_a.size() - b_dw + rd_a.size() - b_rd
            + en_cnt - b_en !== 0) begin
            n_bad++; $display("FAIL zero_ext_activity: got %0d expected 0",
                iw_a.size() - b_iw + dw_a.size() - b_dw + rd_a.size() - b_rd);
        end
    endtask

    task automatic test_start_busy();
        snap();
        @(posedge clk); #1;
        start = 1; imem_len = 2; dmem_len = 0; run_cycles = 0; dump_len = 0;
        @(posedge clk); #1;
        imem_len = 0;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_bad++; $display("FAIL busy_start_ignored: got %b expected 10",
                {busy, done});
        end
        @(posedge clk); #1; in_valid = 1; in_data = 32'h31;
        @(posedge clk); #1; in_data = 32'h32;
        @(posedge clk); #1; in_valid = 0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (iw_a.size() - b_iw !== 2 || done !== 1'b1) begin
            n_bad++; $display("FAIL busy_job_writes: got %0d/%b expected 2/1",
                iw_a.size() - b_iw, done);
        end
        n_cmp++;
        if ({iw_a[b_iw], iw_d[b_iw], iw_a[b_iw+1], iw_d[b_iw+1]} !==
            {32'h0, 32'h31, 32'h4, 32'h32}) begin
            n_bad++; $display("FAIL busy_job_data: got %h %h %h %h expected 0 31 4 32",
                iw_a[b_iw], iw_d[b_iw], iw_a[b_iw+1], iw_d[b_iw+1]);
        end
    endtask

    task automatic test_load();
        logic [31:0] w[8];
        logic [31:0] ei[3], ed[2];
        w = '{32'hA, 32'hB, 32'hC, 32'h11, 32'h22, 0, 0, 0};
        ei = '{32'hA, 32'hB, 32'hC};
        ed = '{32'h11, 32'h22};
        snap();
        run_job(3, 2, 5, 32'h40, 3, w, 1'b1, 1'b1);
        n_cmp++;
        if (iw_a.size() - b_iw !== 3 || dw_a.size() - b_dw !== 2) begin
            n_bad++; $display("FAIL load_counts: got %0d/%0d expected 3/2",
                iw_a.size() - b_iw, dw_a.size() - b_dw);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (iw_a[b_iw+i] !== 32'(i * 4) || iw_d[b_iw+i] !== ei[i] ||
                iw_c[b_iw+i] !== acc_c[b_acc+i] + 1) begin
                n_bad++;
                $display("FAIL imem_write%0d: got %h:%h @%0d expected %h:%h @%0d",
                    i, iw_a[b_iw+i], iw_d[b_iw+i], iw_c[b_iw+i],
                    i * 4, ei[i], acc_c[b_acc+i] + 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (dw_a[b_dw+i] !== 32'(i * 4) || dw_d[b_dw+i] !== ed[i] ||
                dw_c[b_dw+i] !== acc_c[b_acc+3+i] + 1) begin
                n_bad++;
                $display("FAIL dmem_write%0d: got %h:%h @%0d expected %h:%h @%0d",
                    i, dw_a[b_dw+i], dw_d[b_dw+i], dw_c[b_dw+i],
                    i * 4, ed[i], acc_c[b_acc+3+i] + 1);
            end
        end
    endtask

    task automatic test_run();
        n_cmp++;
        if (en_cnt - b_en !== 5 || en_runs - b_runs !== 1) begin
            n_bad++; $display("FAIL run_window: got %0d cycles/%0d runs expected 5/1",
                en_cnt - b_en, en_runs - b_runs);
        end
        n_cmp++;
        if (overlap !== 0) begin
            n_bad++; $display("FAIL run_overlap: got %0d expected 0", overlap);
        end
    endtask

    task automatic test_dump();
        logic [31:0] ea[3], eo[3];
        ea = '{32'h40, 32'h44, 32'h48};
        eo = '{32'hD000_0010, 32'hD000_0011, 32'hD000_0012};
        n_cmp++;
        if (rd_a.size() - b_rd !== 3 || oq.size() - b_oq !== 3) begin
            n_bad++; $display("FAIL dump_counts: got %0d/%0d expected 3/3",
                rd_a.size() - b_rd, oq.size() - b_oq);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rd_a[b_rd+i] !== ea[i] || oq[b_oq+i] !== eo[i]) begin
                n_bad++; $display("FAIL dump_word%0d: got %h/%h expected %h/%h",
                    i, rd_a[b_rd+i], oq[b_oq+i], ea[i], eo[i]);
            end
        end
        n_cmp++;
        if (stall_cyc - b_stall !== 4 || unstable !== 0) begin
            n_bad++; $display("FAIL dump_stall: got %0d stalls/%0d changes expected 4/0",
                stall_cyc - b_stall, unstable);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[8];
        w = '{32'h77, 32'h55, 32'h66, 0, 0, 0, 0, 0};
        snap();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL b2b_from_done: got %b expected 1", done);
        end
        run_job(1, 2, 2, 32'hFFFF_FFFC, 2, w, 1'b0, 1'b0);
        n_cmp++;
        if (iw_a.size() - b_iw !== 1 || iw_a[b_iw] !== 32'h0 ||
            iw_d[b_iw] !== 32'h77) begin
            n_bad++; $display("FAIL b2b_imem: got %0d %h:%h expected 1 0:77",
                iw_a.size() - b_iw, iw_a[b_iw], iw_d[b_iw]);
        end
        n_cmp++;
        if (dw_a.size() - b_dw !== 2 || dw_d[b_dw] !== 32'h55 ||
            dw_a[b_dw+1] !== 32'h4 || dw_d[b_dw+1] !== 32'h66) begin
            n_bad++; $display("FAIL b2b_dmem: got %0d %h %h:%h expected 2 55 4:66",
                dw_a.size() - b_dw, dw_d[b_dw], dw_a[b_dw+1], dw_d[b_dw+1]);
        end
        n_cmp++;
        if (en_cnt - b_en !== 2) begin
            n_bad++; $display("FAIL b2b_run: got %0d expected 2", en_cnt - b_en);
        end
        n_cmp++;
        if (rd_a[b_rd] !== 32'hFFFF_FFFC || rd_a[b_rd+1] !== 32'h0 ||
            rd_a.size() - b_rd !== 2) begin
            n_bad++; $display("FAIL b2b_wrap_addr: got %h %h expected fffffffc 0",
                rd_a[b_rd], rd_a[b_rd+1]);
        end
        n_cmp++;
        if (oq[b_oq] !== 32'hD000_00FF || oq[b_oq+1] !== 32'h55) begin
            n_bad++; $display("FAIL b2b_dump_data: got %h %h expected d00000ff 55",
                oq[b_oq], oq[b_oq+1]);
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (bd !== 0 || ren_i !== 0 || overlap !== 0) begin
            n_bad++; $display("FAIL invariants: got bd=%0d ren=%0d ovl=%0d expected 0",
                bd, ren_i, overlap);
        end
    endtask

    initial begin
        test_reset();
        test_zero_len();
        test_start_busy();
        test_load();
        test_run();
        test_dump();
        test_back_to_back();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
